data_memory_lanes: RTL and testbench

- Parametrised successor of the core's single-port data memory: byte-addressed, little-endian, with true byte-lane stores.
- Sub-word stores preserve the untouched bytes of the word instead of zero-filling them.
- Adds a valid/ready request port, a one-cycle registered response, fault reporting and optional two-beat handling of word-crossing misaligned accesses.
- Sits between the load/store unit and on-chip RAM; load extension (signed/unsigned) is performed here.

---
 rtl/data_memory_lanes.sv | 180 ++++++++++++++++++
 tb/tb_data_memory_lanes.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lanes.sv
// Byte-addressed, little-endian data memory with byte-lane stores, load
// extension, fault reporting and two-beat handling of word-crossing accesses.
module data_memory_lanes #(
    parameter int ADDR_WIDTH         = 8,
    parameter int DEPTH              = 64,
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = ADDR_WIDTH - 2;
    localparam logic [WIDX_W:0] DEPTH_W = (WIDX_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t state, state_next;

    logic [31:0] mem [DEPTH];

    logic [1:0]        off;
    logic [WIDX_W:0]   widx_ext;
    logic [WIDX_W:0]   widx_nxt;
    logic [IDX_W-1:0]  idx_a;
    logic [2:0]        nbytes;
    logic [3:0]        base_mask;
    logic              misaligned;
    logic              crossing;
    logic              fault;
    logic              accept;
    logic              do_split;
    logic [63:0]       wide_data;
    logic [7:0]        wide_mask;
    logic [31:0]       word_a;
    logic [31:0]       split_word;

    // Second-beat context captured when a crossing access is accepted
    logic [IDX_W-1:0]  idx_b_q;
    logic [31:0]       hi_data_q;
    logic [3:0]        hi_mask_q;
    logic [31:0]       lo_word_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              write_q;

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        uns);
        logic [31:0] res;
        case (size)
            2'b01:   res = {{24{raw[7]  & ~uns}}, raw[7:0]};
            2'b10:   res = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign do_split  = accept && !fault && crossing;

    // Decode the presented request: lanes, crossing detection and faults
    always_comb begin
        off      = req_addr[1:0];
        widx_ext = {1'b0, req_addr[ADDR_WIDTH-1:2]};
        widx_nxt = widx_ext + (WIDX_W + 1)'(1);
        idx_a    = req_addr[IDX_W+1:2];
        case (req_size)
            2'b01:   begin nbytes = 3'd1; base_mask = 4'b0001; end
            2'b10:   begin nbytes = 3'd2; base_mask = 4'b0011; end
            2'b11:   begin nbytes = 3'd4; base_mask = 4'b1111; end
            default: begin nbytes = 3'd0; base_mask = 4'b0000; end
        endcase
        misaligned = ((req_size == 2'b10) && req_addr[0]) ||
                     ((req_size == 2'b11) && (off != 2'b00));
        crossing   = ({1'b0, off} + nbytes) > 3'd4;
        fault      = (req_size == 2'b00) ||
                     (widx_ext >= DEPTH_W) ||
                     (!SUPPORT_MISALIGNED && misaligned) ||
                     (crossing && (widx_nxt >= DEPTH_W));
        // Low half of the 64-bit view feeds word A, high half feeds word A+1
        wide_data  = {32'b0, req_wdata} << {off, 3'b000};
        wide_mask  = {4'b0, base_mask} << off;
        word_a     = mem[idx_a];
        split_word = 32'({mem[idx_b_q], lo_word_q} >> {off_q, 3'b000});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: a crossing access spends exactly one cycle in SPLIT
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (do_split) state_next = SPLIT;
            SPLIT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte-lane writes: beat 0 / single beat at accept, beat 1 in SPLIT
    always_ff @(posedge clk) begin
        if (accept && !fault && req_write) begin
            for (int unsigned k = 0; k < 4; k++)
                if (wide_mask[k]) mem[idx_a][8*k +: 8] <= wide_data[8*k +: 8];
        end else if (state == SPLIT && write_q) begin
            for (int unsigned k = 0; k < 4; k++)
                if (hi_mask_q[k]) mem[idx_b_q][8*k +: 8] <= hi_data_q[8*k +: 8];
        end
    end

    // Capture second-beat context for a crossing access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_b_q   <= '0;
            hi_data_q <= '0;
            hi_mask_q <= '0;
            lo_word_q <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            write_q   <= 1'b0;
        end else if (do_split) begin
            idx_b_q   <= widx_nxt[IDX_W-1:0];
            hi_data_q <= wide_data[63:32];
            hi_mask_q <= wide_mask[7:4];
            lo_word_q <= word_a;
            off_q     <= off;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            write_q   <= req_write;
        end
    end

    // Registered response: one pulse per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
            if (accept) begin
                if (fault) begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b1;
                end else if (!crossing) begin
                    rsp_valid <= 1'b1;
                    if (!req_write)
                        rsp_rdata <= extend(word_a >> {off, 3'b000}, req_size, req_unsigned);
                end
            end else if (state == SPLIT) begin
                rsp_valid <= 1'b1;
                if (!write_q)
                    rsp_rdata <= extend(split_word, size_q, uns_q);
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lanes.sv
// Randomised and directed checks of data_memory_lanes against a byte-array model.
module tb_data_memory_lanes;

    localparam int AW    = 9;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write, req_unsigned;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_fault;
    logic [31:0]   rsp_rdata;

    logic          valid2, ready2, write2, uns2, rv2, rf2;
    logic [7:0]    addr2;
    logic [1:0]    size2;
    logic [31:0]   wdata2, rd2;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] mem_m [DEPTH*4];

    always #5 clk = ~clk;

    data_memory_lanes #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .SUPPORT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    data_memory_lanes #(.ADDR_WIDTH(8), .DEPTH(64), .SUPPORT_MISALIGNED(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid2), .req_ready(ready2),
        .req_write(write2), .req_addr(addr2), .req_size(size2),
        .req_unsigned(uns2), .req_wdata(wdata2), .rsp_valid(rv2),
        .rsp_rdata(rd2), .rsp_fault(rf2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    function automatic int sz_bytes(input logic [1:0] s);
        return (s == 2'd0) ? 0 : (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 4;
    endfunction

    function automatic bit m_fault(input logic [1:0] s, input int a);
        int n = sz_bytes(s);
        if (n == 0) return 1'b1;
        if (a / 4 >= DEPTH) return 1'b1;
        if ((a % 4) + n > 4 && (a / 4) + 1 >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_crossing(input logic [1:0] s, input int a);
        return (a % 4) + sz_bytes(s) > 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] s, input int a, input bit u);
        int n = sz_bytes(s);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[a+i]) << (8*i));
        if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic do_req(input bit w, input int a, input logic [1:0] s, input bit u,
                          input logic [31:0] d, input bit keep);
        bit f, cr;
        logic [31:0] want;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a[AW-1:0];
        req_size = s; req_unsigned = u; req_wdata = d;
        check_val("ready_idle", 32'(req_ready), 32'd1);
        f    = m_fault(s, a);
        cr   = !f && m_crossing(s, a);
        want = (f || w) ? 32'd0 : m_load(s, a, u);
        if (!f && w)
            for (int i = 0; i < sz_bytes(s); i++) mem_m[a+i] = d[8*i +: 8];
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
        if (cr) begin
            check_val("split_gap_valid", 32'(rsp_valid), 32'd0);
            check_val("split_busy", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check_val("rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("rsp_fault", 32'(rsp_fault), 32'(f));
        check_val("rsp_rdata", rsp_rdata, want);
    endtask

    task automatic req2(input bit w, input logic [7:0] a, input logic [1:0] s, input bit u,
                        input logic [31:0] d, input bit want_f, input logic [31:0] want_d);
        @(negedge clk);
        valid2 = 1'b1; write2 = w; addr2 = a; size2 = s; uns2 = u; wdata2 = d;
        check_val("ready2", 32'(ready2), 32'd1);
        @(posedge clk); #1;
        valid2 = 1'b0;
        check_val("rsp2_valid", 32'(rv2), 32'd1);
        check_val("rsp2_fault", 32'(rf2), 32'(want_f));
        check_val("rsp2_rdata", rd2, want_d);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = '0;
        valid2 = 1'b0; write2 = 1'b0; addr2 = '0; size2 = 2'd0; uns2 = 1'b0; wdata2 = '0;
        #12;
        check_val("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        check_val("reset_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("reset_ready", 32'(req_ready), 32'd1);

        // Fill every word so the model and the RAM agree from here on
        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 4*w, 2'd3, 1'b0, $urandom, 1'b0);

        // Sub-word store preserves neighbouring bytes
        do_req(1'b1, 'h10, 2'd3, 1'b0, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 'h12, 2'd1, 1'b0, 32'h00000055, 1'b0);
        do_req(1'b0, 'h10, 2'd3, 1'b0, 32'd0, 1'b0);
        check_val("merge_literal", rsp_rdata, 32'hDE55BEEF);

        // Load extension
        do_req(1'b1, 'h10, 2'd3, 1'b0, 32'h80FF0000, 1'b0);
        do_req(1'b0, 'h13, 2'd1, 1'b0, 32'd0, 1'b0);
        check_val("byte_signed_literal", rsp_rdata, 32'hFFFFFF80);
        do_req(1'b0, 'h13, 2'd1, 1'b1, 32'd0, 1'b0);
        check_val("byte_unsigned_literal", rsp_rdata, 32'h00000080);
        do_req(1'b0, 'h12, 2'd2, 1'b0, 32'd0, 1'b0);
        check_val("half_signed_literal", rsp_rdata, 32'hFFFF80FF);

        // Word-crossing store and load
        do_req(1'b1, 'h0C, 2'd3, 1'b0, 32'd0, 1'b0);
        do_req(1'b1, 'h10, 2'd3, 1'b0, 32'd0, 1'b0);
        do_req(1'b1, 'h0E, 2'd3, 1'b0, 32'h11223344, 1'b0);
        do_req(1'b0, 'h0C, 2'd3, 1'b0, 32'd0, 1'b0);
        check_val("split_word3", rsp_rdata, 32'h33440000);
        do_req(1'b0, 'h10, 2'd3, 1'b0, 32'd0, 1'b0);
        check_val("split_word4", rsp_rdata, 32'h00001122);
        do_req(1'b0, 'h0E, 2'd3, 1'b0, 32'd0, 1'b0);
        check_val("split_load", rsp_rdata, 32'h11223344);

        // Faults leave memory untouched
        do_req(1'b1, 'h00, 2'd0, 1'b0, 32'hFFFFFFFF, 1'b0);
        do_req(1'b1, 'h100, 2'd3, 1'b0, 32'hFFFFFFFF, 1'b0);
        do_req(1'b1, 'hFD, 2'd3, 1'b0, 32'hFFFFFFFF, 1'b0);
        do_req(1'b0, 'h00, 2'd3, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 'hFC, 2'd3, 1'b0, 32'd0, 1'b0);

        // Back-to-back aligned stream with req_valid held high
        for (int i = 0; i < 8; i++)
            do_req(~i[0], 'h40 + 4*(i/2), 2'd3, 1'b0, $urandom, 1'b1);
        req_valid = 1'b0;

        // Random traffic, including out-of-range and crossing accesses
        for (int i = 0; i < 150; i++)
            do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 263)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1'b0);

        // Reset while a crossing store waits for its second beat
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 'h0F; req_size = 2'd3;
        req_unsigned = 1'b0; req_wdata = 32'hA1B2C3D4;
        check_val("rst_split_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_m['h0F] = 8'hD4;
        rst_n = 1'b0;
        #1;
        check_val("rst_split_valid0", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check_val("rst_split_valid1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_split_valid2", 32'(rsp_valid), 32'd0);
        check_val("rst_split_ready_after", 32'(req_ready), 32'd1);
        do_req(1'b0, 'h0C, 2'd3, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 'h10, 2'd3, 1'b0, 32'd0, 1'b0);

        // Misaligned-disabled instance
        req2(1'b1, 8'h20, 2'd3, 1'b0, 32'hCAFEF00D, 1'b0, 32'd0);
        req2(1'b0, 8'h01, 2'd2, 1'b0, 32'd0, 1'b1, 32'd0);
        req2(1'b0, 8'h22, 2'd3, 1'b0, 32'd0, 1'b1, 32'd0);
        req2(1'b1, 8'h21, 2'd2, 1'b0, 32'h00001234, 1'b1, 32'd0);
        req2(1'b0, 8'h22, 2'd2, 1'b1, 32'd0, 1'b0, 32'h0000CAFE);
        req2(1'b0, 8'h23, 2'd1, 1'b0, 32'd0, 1'b0, 32'hFFFFFFCA);
        req2(1'b0, 8'h20, 2'd3, 1'b0, 32'd0, 1'b0, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
